// File: rtl/f2c_queue_manager.sv
// Per-queue packet/descriptor ring-state stage ahead of the FPGA-to-CPU DMA engine.
// Define F2C_QM_STATS_EN to enable the out_pkt_cnt / out_flit_cnt statistics counters.
module f2c_queue_manager #(
  parameter int unsigned NB_QUEUES = 16,
  parameter int unsigned QID_W     = $clog2(NB_QUEUES),
  parameter int unsigned RB_AWIDTH = 16,
  parameter int unsigned SIZE_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [QID_W-1:0]     in_qid,
  input  logic [SIZE_W-1:0]    in_size,
  input  logic                 in_needs_dsc,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [QID_W-1:0]     out_qid,
  output logic [SIZE_W-1:0]    out_size,
  output logic                 out_needs_dsc,
  output logic [63:0]          out_pkt_kmem_addr,
  output logic [RB_AWIDTH-1:0] out_pkt_head,
  output logic [RB_AWIDTH-1:0] out_pkt_tail,
  output logic [63:0]          out_dsc_kmem_addr,
  output logic [RB_AWIDTH-1:0] out_dsc_head,
  output logic [RB_AWIDTH-1:0] out_dsc_tail,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [RB_AWIDTH:0]   pkt_rb_size,
  input  logic [RB_AWIDTH:0]   dsc_rb_size,
  input  logic                 cfg_wr_en,
  input  logic                 cfg_wr_dsc,
  input  logic                 cfg_wr_is_head,
  input  logic [QID_W-1:0]     cfg_wr_qid,
  input  logic [63:0]          cfg_wr_data,
  input  logic                 sw_reset,
  output logic [31:0]          drop_cnt,
  output logic [31:0]          out_pkt_cnt,
  output logic [31:0]          out_flit_cnt
);

  localparam int unsigned AddW = ((SIZE_W > RB_AWIDTH) ? SIZE_W : RB_AWIDTH) + 1;
  localparam logic [RB_AWIDTH:0] OneR = {{RB_AWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StLookup, StEmit} state_e;

  state_e state_q, state_d;
  logic   rdy_en_q;

  logic [63:0]          pkt_kmem_q [NB_QUEUES];
  logic [63:0]          pkt_kmem_d [NB_QUEUES];
  logic [RB_AWIDTH-1:0] pkt_head_q [NB_QUEUES];
  logic [RB_AWIDTH-1:0] pkt_head_d [NB_QUEUES];
  logic [RB_AWIDTH-1:0] pkt_tail_q [NB_QUEUES];
  logic [RB_AWIDTH-1:0] pkt_tail_d [NB_QUEUES];
  logic [63:0]          dsc_kmem_q [NB_QUEUES];
  logic [63:0]          dsc_kmem_d [NB_QUEUES];
  logic [RB_AWIDTH-1:0] dsc_head_q [NB_QUEUES];
  logic [RB_AWIDTH-1:0] dsc_head_d [NB_QUEUES];
  logic [RB_AWIDTH-1:0] dsc_tail_q [NB_QUEUES];
  logic [RB_AWIDTH-1:0] dsc_tail_d [NB_QUEUES];

  logic [QID_W-1:0]  lat_qid_q, lat_qid_d;
  logic [SIZE_W-1:0] lat_size_q, lat_size_d;
  logic              lat_nd_q, lat_nd_d;

  logic [QID_W-1:0]     out_qid_q;
  logic [SIZE_W-1:0]    out_size_q;
  logic                 out_nd_q;
  logic [63:0]          out_pkt_kmem_q, out_dsc_kmem_q;
  logic [RB_AWIDTH-1:0] out_pkt_head_q, out_pkt_tail_q, out_dsc_head_q, out_dsc_tail_q;

  logic [31:0] drop_cnt_q;

  // Snapshot of the latched queue's ring state, taken from the registered table so that a
  // config write in the LOOKUP cycle only affects later packets.
  logic [63:0]          snap_pkt_kmem, snap_dsc_kmem;
  logic [RB_AWIDTH-1:0] snap_pkt_head, snap_pkt_tail, snap_dsc_head, snap_dsc_tail;
  logic [RB_AWIDTH:0]   pkt_free, dsc_free, dsc_sum;
  logic [AddW-1:0]      pkt_sum;
  logic [RB_AWIDTH-1:0] pkt_tail_nxt, dsc_tail_nxt;
  logic                 pass_thru, fit;
  logic                 load_out, advance, drop_inc;

  always_comb begin
    snap_pkt_kmem = pkt_kmem_q[lat_qid_q];
    snap_pkt_head = pkt_head_q[lat_qid_q];
    snap_pkt_tail = pkt_tail_q[lat_qid_q];
    snap_dsc_kmem = dsc_kmem_q[lat_qid_q];
    snap_dsc_head = dsc_head_q[lat_qid_q];
    snap_dsc_tail = dsc_tail_q[lat_qid_q];

    pkt_free = (snap_pkt_tail >= snap_pkt_head)
             ? pkt_rb_size - {1'b0, snap_pkt_tail} + {1'b0, snap_pkt_head} - OneR
             : {1'b0, snap_pkt_head} - {1'b0, snap_pkt_tail} - OneR;
    dsc_free = (snap_dsc_tail >= snap_dsc_head)
             ? dsc_rb_size - {1'b0, snap_dsc_tail} + {1'b0, snap_dsc_head} - OneR
             : {1'b0, snap_dsc_head} - {1'b0, snap_dsc_tail} - OneR;

    pass_thru = (snap_pkt_kmem == 64'd0) || (snap_dsc_kmem == 64'd0);
    fit       = (AddW'(pkt_free) >= AddW'(lat_size_q)) && (!lat_nd_q || (dsc_free != '0));

    pkt_sum      = AddW'(snap_pkt_tail) + AddW'(lat_size_q);
    pkt_tail_nxt = (pkt_sum >= AddW'(pkt_rb_size)) ? RB_AWIDTH'(pkt_sum - AddW'(pkt_rb_size))
                                                    : RB_AWIDTH'(pkt_sum);
    dsc_sum      = {1'b0, snap_dsc_tail} + OneR;
    dsc_tail_nxt = (dsc_sum >= dsc_rb_size) ? RB_AWIDTH'(dsc_sum - dsc_rb_size)
                                            : RB_AWIDTH'(dsc_sum);
  end

  assign in_ready  = (state_q == StIdle) && rdy_en_q;
  assign out_valid = (state_q == StEmit);

  always_comb begin
    state_d    = state_q;
    lat_qid_d  = lat_qid_q;
    lat_size_d = lat_size_q;
    lat_nd_d   = lat_nd_q;
    load_out   = 1'b0;
    advance    = 1'b0;
    drop_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          lat_qid_d  = in_qid;
          lat_size_d = in_size;
          lat_nd_d   = in_needs_dsc;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        if (pass_thru) begin
          load_out = 1'b1;
          state_d  = StEmit;
        end else if (fit) begin
          load_out = 1'b1;
          advance  = 1'b1;
          state_d  = StEmit;
        end else begin
          drop_inc = 1'b1;
          state_d  = StIdle;
        end
      end
      StEmit: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Config writes are applied after the tail advance so a kmem_addr write wins on the tail.
  always_comb begin
    pkt_kmem_d = pkt_kmem_q;
    pkt_head_d = pkt_head_q;
    pkt_tail_d = pkt_tail_q;
    dsc_kmem_d = dsc_kmem_q;
    dsc_head_d = dsc_head_q;
    dsc_tail_d = dsc_tail_q;
    if (advance) begin
      pkt_tail_d[lat_qid_q] = pkt_tail_nxt;
      if (lat_nd_q) dsc_tail_d[lat_qid_q] = dsc_tail_nxt;
    end
    if (cfg_wr_en) begin
      if (!cfg_wr_dsc) begin
        if (cfg_wr_is_head) begin
          pkt_head_d[cfg_wr_qid] = cfg_wr_data[RB_AWIDTH-1:0];
        end else begin
          pkt_kmem_d[cfg_wr_qid] = cfg_wr_data;
          pkt_head_d[cfg_wr_qid] = '0;
          pkt_tail_d[cfg_wr_qid] = '0;
        end
      end else begin
        if (cfg_wr_is_head) begin
          dsc_head_d[cfg_wr_qid] = cfg_wr_data[RB_AWIDTH-1:0];
        end else begin
          dsc_kmem_d[cfg_wr_qid] = cfg_wr_data;
          dsc_head_d[cfg_wr_qid] = '0;
          dsc_tail_d[cfg_wr_qid] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rdy_en_q   <= 1'b0;
      lat_qid_q  <= '0;
      lat_size_q <= '0;
      lat_nd_q   <= 1'b0;
      pkt_kmem_q <= '{default: '0};
      pkt_head_q <= '{default: '0};
      pkt_tail_q <= '{default: '0};
      dsc_kmem_q <= '{default: '0};
      dsc_head_q <= '{default: '0};
      dsc_tail_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      lat_qid_q  <= lat_qid_d;
      lat_size_q <= lat_size_d;
      lat_nd_q   <= lat_nd_d;
      pkt_kmem_q <= pkt_kmem_d;
      pkt_head_q <= pkt_head_d;
      pkt_tail_q <= pkt_tail_d;
      dsc_kmem_q <= dsc_kmem_d;
      dsc_head_q <= dsc_head_d;
      dsc_tail_q <= dsc_tail_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_qid_q      <= '0;
      out_size_q     <= '0;
      out_nd_q       <= 1'b0;
      out_pkt_kmem_q <= '0;
      out_pkt_head_q <= '0;
      out_pkt_tail_q <= '0;
      out_dsc_kmem_q <= '0;
      out_dsc_head_q <= '0;
      out_dsc_tail_q <= '0;
    end else if (load_out) begin
      out_qid_q      <= lat_qid_q;
      out_size_q     <= lat_size_q;
      out_nd_q       <= lat_nd_q;
      out_pkt_kmem_q <= snap_pkt_kmem;
      out_pkt_head_q <= snap_pkt_head;
      out_pkt_tail_q <= snap_pkt_tail;
      out_dsc_kmem_q <= snap_dsc_kmem;
      out_dsc_head_q <= snap_dsc_head;
      out_dsc_tail_q <= snap_dsc_tail;
    end
  end

  assign out_qid           = out_qid_q;
  assign out_size          = out_size_q;
  assign out_needs_dsc     = out_nd_q;
  assign out_pkt_kmem_addr = out_pkt_kmem_q;
  assign out_pkt_head      = out_pkt_head_q;
  assign out_pkt_tail      = out_pkt_tail_q;
  assign out_dsc_kmem_addr = out_dsc_kmem_q;
  assign out_dsc_head      = out_dsc_head_q;
  assign out_dsc_tail      = out_dsc_tail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (sw_reset) begin
      drop_cnt_q <= '0;
    end else if (drop_inc && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;

`ifdef F2C_QM_STATS_EN
  logic [31:0] pkt_cnt_q, flit_cnt_q;
  logic [32:0] flit_sum;
  logic        out_hs;

  assign out_hs   = out_valid && out_ready;
  assign flit_sum = {1'b0, flit_cnt_q} + 33'(out_size_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else if (sw_reset) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else if (out_hs) begin
      if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      flit_cnt_q <= flit_sum[32] ? '1 : flit_sum[31:0];
    end
  end

  assign out_pkt_cnt  = pkt_cnt_q;
  assign out_flit_cnt = flit_cnt_q;
`else
  assign out_pkt_cnt  = '0;
  assign out_flit_cnt = '0;
`endif

  a_size_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready) |-> (in_size != '0));
  a_size_fits: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready) |-> (AddW'(in_size) < AddW'(pkt_rb_size)));

endmodule

// File: tb/tb_f2c_queue_manager.sv
// Randomized self-checking bench for f2c_queue_manager against a transaction-level ring model.
module tb_f2c_queue_manager;

  localparam int unsigned NQ = 16;
  localparam int unsigned QW = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [QW-1:0] in_qid = '0;
  logic [SW-1:0] in_size = '0;
  logic          in_needs_dsc = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [QW-1:0] out_qid;
  logic [SW-1:0] out_size;
  logic          out_needs_dsc;
  logic [63:0]   out_pkt_kmem_addr, out_dsc_kmem_addr;
  logic [AW-1:0] out_pkt_head, out_pkt_tail, out_dsc_head, out_dsc_tail;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW:0]   pkt_rb_size = 17'd64;
  logic [AW:0]   dsc_rb_size = 17'd64;
  logic          cfg_wr_en = 1'b0;
  logic          cfg_wr_dsc = 1'b0;
  logic          cfg_wr_is_head = 1'b0;
  logic [QW-1:0] cfg_wr_qid = '0;
  logic [63:0]   cfg_wr_data = '0;
  logic          sw_reset = 1'b0;
  logic [31:0]   drop_cnt, out_pkt_cnt, out_flit_cnt;

  f2c_queue_manager #(
    .NB_QUEUES(NQ), .QID_W(QW), .RB_AWIDTH(AW), .SIZE_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_qid(in_qid), .in_size(in_size), .in_needs_dsc(in_needs_dsc),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_qid(out_qid), .out_size(out_size), .out_needs_dsc(out_needs_dsc),
    .out_pkt_kmem_addr(out_pkt_kmem_addr), .out_pkt_head(out_pkt_head),
    .out_pkt_tail(out_pkt_tail), .out_dsc_kmem_addr(out_dsc_kmem_addr),
    .out_dsc_head(out_dsc_head), .out_dsc_tail(out_dsc_tail),
    .out_valid(out_valid), .out_ready(out_ready),
    .pkt_rb_size(pkt_rb_size), .dsc_rb_size(dsc_rb_size),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_dsc(cfg_wr_dsc), .cfg_wr_is_head(cfg_wr_is_head),
    .cfg_wr_qid(cfg_wr_qid), .cfg_wr_data(cfg_wr_data),
    .sw_reset(sw_reset), .drop_cnt(drop_cnt),
    .out_pkt_cnt(out_pkt_cnt), .out_flit_cnt(out_flit_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: ring state per queue, plus counters.
  logic [63:0] m_pkt_kmem [NQ];
  logic [63:0] m_dsc_kmem [NQ];
  int m_pkt_head [NQ];
  int m_pkt_tail [NQ];
  int m_dsc_head [NQ];
  int m_dsc_tail [NQ];
  int m_drop, m_pkts, m_flits;
  int psz = 64;
  int dsz = 64;

  logic [63:0] cap_pkt_kmem;
  int cap_pkt_tail, cap_dsc_tail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) begin
      m_pkt_kmem[i] = '0; m_dsc_kmem[i] = '0;
      m_pkt_head[i] = 0;  m_pkt_tail[i] = 0;
      m_dsc_head[i] = 0;  m_dsc_tail[i] = 0;
    end
    m_drop = 0; m_pkts = 0; m_flits = 0;
  endtask

  task automatic model_cfg(input bit dsc, input bit is_head, input int q, input logic [63:0] d);
    if (!dsc) begin
      if (is_head) m_pkt_head[q] = int'(d[15:0]);
      else begin m_pkt_kmem[q] = d; m_pkt_head[q] = 0; m_pkt_tail[q] = 0; end
    end else begin
      if (is_head) m_dsc_head[q] = int'(d[15:0]);
      else begin m_dsc_kmem[q] = d; m_dsc_head[q] = 0; m_dsc_tail[q] = 0; end
    end
  endtask

  task automatic check_counters();
    check_eq("drop_cnt", drop_cnt, m_drop);
`ifdef F2C_QM_STATS_EN
    check_eq("out_pkt_cnt", out_pkt_cnt, m_pkts);
    check_eq("out_flit_cnt", out_flit_cnt, m_flits);
`else
    check_eq("out_pkt_cnt_tied", out_pkt_cnt, 0);
    check_eq("out_flit_cnt_tied", out_flit_cnt, 0);
`endif
  endtask

  // All tasks start and end just after a falling edge.
  task automatic cfg_write(input bit dsc, input bit is_head, input int q, input logic [63:0] d);
    cfg_wr_en = 1'b1; cfg_wr_dsc = dsc; cfg_wr_is_head = is_head;
    cfg_wr_qid = QW'(q); cfg_wr_data = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    model_cfg(dsc, is_head, q, d);
  endtask

  task automatic send_pkt(input int q, input int size, input bit nd, input int delay,
                          input bit cen, input bit cdsc, input bit chead, input int cq,
                          input logic [63:0] cdata);
    logic [63:0] pk, dk;
    int ph, pt, dh, dt, pfree, dfree, n;
    bit pass, fit, exp_emit;
    pk = m_pkt_kmem[q]; ph = m_pkt_head[q]; pt = m_pkt_tail[q];
    dk = m_dsc_kmem[q]; dh = m_dsc_head[q]; dt = m_dsc_tail[q];
    pfree = (pt >= ph) ? psz - pt + ph - 1 : ph - pt - 1;
    dfree = (dt >= dh) ? dsz - dt + dh - 1 : dh - dt - 1;
    pass = (pk == 0) || (dk == 0);
    fit = (pfree >= size) && (!nd || dfree != 0);
    exp_emit = pass || fit;

    in_qid = QW'(q); in_size = SW'(size); in_needs_dsc = nd; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check_eq("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (cen) begin
      cfg_wr_en = 1'b1; cfg_wr_dsc = cdsc; cfg_wr_is_head = chead;
      cfg_wr_qid = QW'(cq); cfg_wr_data = cdata;
    end
    @(negedge clk);
    cfg_wr_en = 1'b0;

    if (!pass && fit) begin
      m_pkt_tail[q] = (pt + size) % psz;
      if (nd) m_dsc_tail[q] = (dt + 1) % dsz;
    end
    if (!exp_emit) m_drop++;
    if (cen) model_cfg(cdsc, chead, cq, cdata);

    n = 0;
    while (!out_valid && n < 3) begin @(negedge clk); n++; end
    check_eq("emitted", out_valid, exp_emit);
    if (exp_emit && out_valid) begin
      check_eq("out_qid", out_qid, q);
      check_eq("out_size", out_size, size);
      check_eq("out_needs_dsc", out_needs_dsc, nd);
      check_eq("out_pkt_kmem", out_pkt_kmem_addr, pk);
      check_eq("out_pkt_head", out_pkt_head, ph);
      check_eq("out_pkt_tail", out_pkt_tail, pt);
      check_eq("out_dsc_kmem", out_dsc_kmem_addr, dk);
      check_eq("out_dsc_head", out_dsc_head, dh);
      check_eq("out_dsc_tail", out_dsc_tail, dt);
      cap_pkt_kmem = out_pkt_kmem_addr;
      cap_pkt_tail = int'(out_pkt_tail);
      cap_dsc_tail = int'(out_dsc_tail);
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_in_ready", in_ready, 0);
        check_eq("hold_pkt_tail", out_pkt_tail, pt);
        check_eq("hold_dsc_tail", out_dsc_tail, dt);
        check_eq("hold_pkt_kmem", out_pkt_kmem_addr, pk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      m_pkts++;
      m_flits += size;
      check_eq("valid_after_hs", out_valid, 0);
    end
    check_counters();
  endtask

  task automatic send(input int q, input int size, input bit nd, input int delay);
    send_pkt(q, size, nd, delay, 1'b0, 1'b0, 1'b0, 0, 64'd0);
  endtask

  task automatic do_sw_reset();
    sw_reset = 1'b1;
    @(negedge clk);
    sw_reset = 1'b0;
    m_drop = 0; m_pkts = 0; m_flits = 0;
    check_counters();
  endtask

  initial begin
    int n;
    model_reset();
    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_pkt_tail", out_pkt_tail, 0);
    check_eq("rst_out_kmem", out_pkt_kmem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("in_ready_after_release", in_ready, 0);
    @(negedge clk);
    check_eq("in_ready_idle", in_ready, 1);
    check_counters();

    // Basic advance on queue 3.
    cfg_write(1'b0, 1'b0, 3, 64'h1000);
    cfg_write(1'b1, 1'b0, 3, 64'h2000);
    send(3, 5, 1'b1, 0);
    check_eq("q3_first_pkt_tail", cap_pkt_tail, 0);
    check_eq("q3_first_dsc_tail", cap_dsc_tail, 0);
    check_eq("q3_first_kmem", cap_pkt_kmem, 64'h1000);
    send(3, 5, 1'b1, 1);
    check_eq("q3_second_pkt_tail", cap_pkt_tail, 5);
    check_eq("q3_second_dsc_tail", cap_dsc_tail, 1);

    // Wrap on queue 6.
    cfg_write(1'b0, 1'b0, 6, 64'h6000);
    cfg_write(1'b1, 1'b0, 6, 64'h7000);
    for (int i = 0; i < 12; i++) send(6, 5, 1'b0, 0);
    cfg_write(1'b0, 1'b1, 6, 64'd10);
    send(6, 6, 1'b0, 0);
    check_eq("wrap_emit_tail", cap_pkt_tail, 60);
    send(6, 1, 1'b0, 0);
    check_eq("wrap_next_tail", cap_pkt_tail, 2);

    // Drop on queue 5, then retry after a head update.
    cfg_write(1'b0, 1'b0, 5, 64'h3000);
    cfg_write(1'b1, 1'b0, 5, 64'h4000);
    for (int i = 0; i < 12; i++) send(5, 5, 1'b0, 0);
    send(5, 4, 1'b0, 0);
    check_eq("drop_cnt_one", drop_cnt, 1);
    cfg_write(1'b0, 1'b1, 5, 64'd8);
    send(5, 4, 1'b0, 0);
    check_eq("retry_tail", cap_pkt_tail, 60);
    send(5, 1, 1'b0, 0);
    check_eq("retry_wrap_tail", cap_pkt_tail, 0);

    // Pass-through on an unconfigured queue with downstream stalled.
    send(9, 7, 1'b1, 5);
    send(9, 3, 1'b1, 2);
    check_eq("pass_no_advance", cap_pkt_tail, 0);

    // Config writes landing in the LOOKUP cycle.
    send_pkt(3, 5, 1'b1, 0, 1'b1, 1'b0, 1'b0, 3, 64'h5000);
    check_eq("cfg_race_snapshot_kmem", cap_pkt_kmem, 64'h1000);
    check_eq("cfg_race_snapshot_tail", cap_pkt_tail, 10);
    send(3, 1, 1'b0, 0);
    check_eq("cfg_race_tail_cleared", cap_pkt_tail, 0);
    check_eq("cfg_race_new_kmem", cap_pkt_kmem, 64'h5000);
    send_pkt(6, 2, 1'b0, 0, 1'b1, 1'b0, 1'b1, 6, 64'd3);
    send(6, 1, 1'b0, 0);
    check_eq("head_race_tail", cap_pkt_tail, 5);

    do_sw_reset();
    send(9, 1, 1'b0, 0);
    send(9, 8, 1'b0, 0);
    send(9, 20, 1'b1, 0);
`ifdef F2C_QM_STATS_EN
    check_eq("stats_pkts", out_pkt_cnt, 3);
    check_eq("stats_flits", out_flit_cnt, 29);
`endif
    do_sw_reset();

    // Asynchronous reset while a packet is being presented.
    in_qid = 4'd3; in_size = 16'd2; in_needs_dsc = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_reset_emit", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_kills_valid", out_valid, 0);
    check_eq("reset_clears_kmem_out", out_pkt_kmem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("in_ready_after_rerelease", in_ready, 0);
    model_reset();
    @(negedge clk);
    send(3, 2, 1'b1, 0);
    check_eq("table_zeroed_kmem", cap_pkt_kmem, 0);
    check_eq("table_zeroed_tail", cap_pkt_tail, 0);

    // Randomized traffic with a small descriptor ring.
    dsc_rb_size = 17'd16;
    dsz = 16;
    for (int i = 0; i < NQ; i++) begin
      if ($urandom_range(0, 7) != 0) begin
        cfg_write(1'b0, 1'b0, i, 64'h1_0000 + 64'(i) * 64'h100);
        cfg_write(1'b1, 1'b0, i, 64'h2_0000 + 64'(i) * 64'h100);
      end
    end
    for (int it = 0; it < 300; it++) begin
      int q, sel;
      bit cdsc, chead;
      logic [63:0] cdata;
      q = $urandom_range(0, NQ - 1);
      sel = $urandom_range(0, 9);
      cdsc = 1'($urandom_range(0, 1));
      chead = ($urandom_range(0, 5) != 0);
      if (chead) cdata = 64'($urandom_range(0, cdsc ? dsz - 1 : psz - 1));
      else cdata = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'h8000 + 64'($urandom_range(1, 999));
      if (sel == 0) begin
        cfg_write(cdsc, chead, q, cdata);
      end else if (sel == 1) begin
        send_pkt(q, $urandom_range(1, 20), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 1'b1, cdsc, chead, $urandom_range(0, 1) ? q : int'($urandom_range(0, NQ - 1)),
                 cdata);
      end else begin
        send(q, $urandom_range(1, 20), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
